// File: rtl/signed_div_pkg.sv
// signed_div_pkg
// Shared definitions for the sequential signed divider:
//   div_state_t : FSM state encoding (S_IDLE=0, S_CALC=1, S_FIX=2)
//   clog2()     : counter width helper, never returns less than 1

package signed_div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } div_state_t;

   function automatic int clog2(input int value);
      int bits;
      int v;
      bits = 0;
      v = value - 1;
      while (v > 0) begin
         bits++;
         v = v >> 1;
      end
      if (bits < 1) bits = 1;
      return bits;
   endfunction

endpackage

// File: rtl/div_restore_step.sv
// div_restore_step
// One combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_in   [WIDTH:0]   partial remainder before the step
//   dvd_msb              next dividend bit shifted into the remainder
//   dsr_mag  [WIDTH-1:0] divisor magnitude
//   rem_out  [WIDTH:0]   partial remainder after the step
//   q_bit                quotient bit produced by this step

module div_restore_step #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   rem_in,
   input  logic             dvd_msb,
   input  logic [WIDTH-1:0] dsr_mag,
   output logic [WIDTH:0]   rem_out,
   output logic             q_bit
);

   // One extra bit beyond the register so the compare sees the carry out
   // of the shift.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH:0]   diff;

   assign shifted = {rem_in, dvd_msb};
   assign q_bit   = (shifted >= {2'b00, dsr_mag});
   assign diff    = shifted[WIDTH:0] - {1'b0, dsr_mag};
   assign rem_out = q_bit ? diff : shifted[WIDTH:0];

endmodule

// File: rtl/signed_divider_seq.sv
// signed_divider_seq
// Sequential two's-complement signed divider: restoring division on
// operand magnitudes (one quotient bit per clock) followed by a sign fix.
// Optional macro: DIV_OVERFLOW_FLAG_EN adds the overflow output.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 request, sampled only in IDLE
//   dividend, divisor     signed operands, captured on the accepting edge
//   busy                  operation in progress
//   done                  one-cycle pulse when results are valid
//   quotient, remainder   signed results, held until the next done
//   div_by_zero           zero divisor flag, held with the results
//   overflow              (macro only) most-negative / -1 flag
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | waiting for start; captures operands on acceptance
// S_CALC | one restoring step per clock, WIDTH steps total
// S_FIX  | apply signs, register results, pulse done

module signed_divider_seq
   import signed_div_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
`ifdef DIV_OVERFLOW_FLAG_EN
   ,
   output logic             overflow
`endif
);

   localparam int CNT_W = clog2(WIDTH);

   div_state_t       state;
   logic [WIDTH:0]   rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr_mag;
   logic [WIDTH-1:0] dd_raw;
   logic             sign_ds;
   logic             dz;
   logic [CNT_W-1:0] count;

   logic [WIDTH:0]   rem_next;
   logic             q_bit;
   logic [WIDTH-1:0] q_signed;
   logic [WIDTH-1:0] r_signed;

   div_restore_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .dvd_msb (dvd[WIDTH-1]),
      .dsr_mag (dsr_mag),
      .rem_out (rem_next),
      .q_bit   (q_bit)
   );

   // After the last step dvd holds the quotient magnitude and the low
   // WIDTH bits of rem hold the remainder magnitude.
   always_comb begin
      q_signed = dvd;
      r_signed = rem[WIDTH-1:0];
      if (dd_raw[WIDTH-1] ^ sign_ds) q_signed = ~dvd + WIDTH'(1);
      if (dd_raw[WIDTH-1])           r_signed = ~rem[WIDTH-1:0] + WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         rem         <= '0;
         dvd         <= '0;
         dsr_mag     <= '0;
         dd_raw      <= '0;
         sign_ds     <= 1'b0;
         dz          <= 1'b0;
         count       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
`ifdef DIV_OVERFLOW_FLAG_EN
         overflow    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  // Magnitudes are WIDTH-bit unsigned, so the most
                  // negative value maps onto its own bit pattern.
                  dvd     <= dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
                  dsr_mag <= divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
                  dd_raw  <= dividend;
                  sign_ds <= divisor[WIDTH-1];
                  dz      <= (divisor == '0);
                  rem     <= '0;
                  count   <= CNT_W'(WIDTH - 1);
                  busy    <= 1'b1;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               rem <= rem_next;
               dvd <= {dvd[WIDTH-2:0], q_bit};
               if (count == '0) state <= S_FIX;
               else             count <= count - 1'b1;
            end
            S_FIX: begin
               if (dz) begin
                  quotient  <= '1;
                  remainder <= dd_raw;
               end else begin
                  quotient  <= q_signed;
                  remainder <= r_signed;
               end
               div_by_zero <= dz;
`ifdef DIV_OVERFLOW_FLAG_EN
               overflow    <= (dd_raw == {1'b1, {(WIDTH-1){1'b0}}}) && sign_ds
                              && (dsr_mag == WIDTH'(1));
`endif
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Testbench for signed_divider_seq (WIDTH=4): directed cases, randomized
// exhaustive sweep, scoreboard queue fed by the driver and drained by a
// monitor on done.

module tb_signed_divider_seq;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      logic         ov;
      int           done_cyc;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;
`ifdef DIV_OVERFLOW_FLAG_EN
   logic         overflow;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   signed_divider_seq #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
`ifdef DIV_OVERFLOW_FLAG_EN
      ,
      .overflow    (overflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain signed integer arithmetic (SV / and % truncate toward zero).
   function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv);
      exp_t e;
      logic signed [W-1:0] sdd;
      logic signed [W-1:0] sdv;
      int a;
      int b;
      sdd = dd;
      sdv = dv;
      a = sdd;
      b = sdv;
      e.done_cyc = 0;
      e.ov = (a == -(1 << (W-1))) && (b == -1);
      if (b == 0) begin
         e.q  = '1;
         e.r  = dd;
         e.dz = 1'b1;
      end else begin
         e.q  = W'(a / b);
         e.r  = W'(a % b);
         e.dz = 1'b0;
      end
      return e;
   endfunction

   // Monitor: pops on every done, checks pulse width and output hold.
   initial begin : monitor
      exp_t         e;
      logic         prev_done;
      logic         have_last;
      logic [W-1:0] last_q;
      logic [W-1:0] last_r;
      logic         last_dz;
      prev_done = 1'b0;
      have_last = 1'b0;
      last_q = '0;
      last_r = '0;
      last_dz = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            have_last = 1'b0;
         end else if (done) begin
            check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            check("busy_at_done", {31'd0, busy}, 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0 (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("quotient", {28'd0, quotient}, {28'd0, e.q});
               check("remainder", {28'd0, remainder}, {28'd0, e.r});
               check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
               check("latency_cycle", cyc, e.done_cyc);
`ifdef DIV_OVERFLOW_FLAG_EN
               check("overflow", {31'd0, overflow}, {31'd0, e.ov});
`endif
            end
            have_last = 1'b1;
            last_q  = quotient;
            last_r  = remainder;
            last_dz = div_by_zero;
         end else if (have_last) begin
            check("hold_results", {23'd0, quotient, remainder, div_by_zero},
                  {23'd0, last_q, last_r, last_dz});
         end
         prev_done = rst_n ? done : 1'b0;
      end
   end

   // Issue one division; returns at the negedge where done is seen so the
   // next call can start back-to-back.
   task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input bit inject);
      exp_t e;
      bit   got;
      e = model(dd, dv);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1;
      e.done_cyc = cyc + W + 1;
      sb.push_back(e);
      start = 1'b0;
      if (inject) begin
         @(negedge clk);
         dividend = ~dd;
         divisor  = dd ^ 4'h5;
         start    = 1'b1;
         @(negedge clk);
         start    = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 3*W + 10; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=0 required=1 (dd=%0h dv=%0h)", dd, dv);
      end
   endtask

   initial begin : driver
      int p;
      int off;
      int idx;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clk);
      check("reset_outputs", {21'd0, busy, done, quotient, remainder, div_by_zero},
            32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(4'b1001, 4'b0010, 1'b0);
      run_op(4'b0111, 4'b1110, 1'b1);
      run_op(4'b1000, 4'b1111, 1'b0);
      run_op(4'b0101, 4'b0000, 1'b0);
      repeat (3) @(negedge clk);
      run_op(4'b0110, 4'b0011, 1'b0);

      // Abort an operation with reset in the middle of CALC.
      dividend = 4'b0110;
      divisor  = 4'b0011;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_mid_op", {21'd0, busy, done, quotient, remainder, div_by_zero},
            32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 4) @(negedge clk);
      run_op(4'b1010, 4'b0011, 1'b0);

      // Exhaustive sweep in a random order with random gaps and stray starts.
      p   = 2 * $urandom_range(0, 127) + 1;
      off = $urandom_range(0, 255);
      for (int i = 0; i < 256; i++) begin
         idx = (i * p + off) % 256;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_op(W'(idx >> 4), W'(idx), $urandom_range(0, 7) == 0);
      end

      repeat (W + 4) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/signed_divider_seq.md
Name: signed_divider_seq

Overview:
- Sequential two's-complement signed divider. It is the inverse operation of the team's combinational signed_multiplier.
- Restoring division on operand magnitudes, one quotient bit per clock, followed by a sign-correction cycle.
- Uses a start/busy/done handshake so an arithmetic datapath or test controller can issue one division at a time.

Parameters:
- WIDTH, 4, operand/result width in bits (two's complement); legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  signed dividend; captured on the accepting edge
- divisor  input  WIDTH  signed divisor; captured on the accepting edge
- busy  output  1  high from the edge after acceptance until done is asserted
- done  output  1  one-cycle pulse when results are valid
- quotient  output  WIDTH  signed quotient; held until the next done
- remainder  output  WIDTH  signed remainder; held until the next done
- div_by_zero  output  1  high alongside the results of a zero-divisor operation; held with the results

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, internal registers=0.
- States:
  - IDLE: start=1 captures |dividend|, |divisor|, the two sign bits and zero-divisor detect, clears the partial remainder, loads count=WIDTH-1, then goes to CALC.
  - CALC: one restoring step per cycle: shift {rem,dvd} left by 1; if rem >= |divisor| then subtract and set quotient bit. Decrement count; after the WIDTH-th step go to FIX.
  - FIX: apply signs, register outputs, pulse done, go to IDLE.
- Latency: start accepted at edge 0; done is high for exactly the cycle following edge WIDTH+1. The next start can be accepted at edge WIDTH+2, i.e. back-to-back with the done cycle.
- Sign rules:
  - Quotient is truncated toward zero; negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: dividend = quotient*divisor + remainder, modulo 2^WIDTH.
- Width rule: magnitudes are held as WIDTH-bit unsigned values, so -2^(WIDTH-1) is representable. The partial remainder is WIDTH+1 bits to hold the carry of the compare/subtract.
- Overflow: most-negative / -1 gives quotient = most-negative (wraps), remainder=0. No error is raised unless DIV_OVERFLOW_FLAG_EN is defined.
- Divide by zero:
  - Latency is unchanged.
  - quotient = all ones, remainder = the original dividend, div_by_zero=1.
- start while busy (CALC/FIX): ignored; operands are not re-sampled.
- Output hold: quotient, remainder and div_by_zero hold their values until the next FIX cycle overwrites them.
- Reset mid-operation: immediately returns to IDLE with all outputs at their reset values. No done is produced for the aborted operation.

Optional Feature:
- Macro: DIV_OVERFLOW_FLAG_EN.
- When defined:
  - Adds output port overflow (1 bit).
  - overflow is set in FIX when dividend = -2^(WIDTH-1) and divisor = -1, and is held with the results.
  - Reset value 0.
- When undefined: no overflow port and no overflow logic; the wrap result above is unchanged.

Decomposition:
- Package signed_div_pkg:
  - state encoding localparams S_IDLE=2'd0, S_CALC=2'd1, S_FIX=2'd2;
  - counter width function clog2(WIDTH).
- One natural sub-module, div_restore_step: combinational single restoring step. Inputs partial remainder, dividend MSB and divisor magnitude; outputs next remainder and quotient bit. Instantiated once in CALC.

Test Plan (WIDTH=4):
- dividend=4'b1001 (-7), divisor=4'b0010 (+2), start pulse -> done at edge 5; quotient=4'b1101 (-3), remainder=4'b1111 (-1), div_by_zero=0.
- dividend=4'b0111 (+7), divisor=4'b1110 (-2) -> quotient=4'b1101 (-3), remainder=4'b0001 (+1); a second start asserted during CALC is ignored (single done, results unchanged).
- dividend=4'b1000 (-8), divisor=4'b1111 (-1) -> quotient=4'b1000, remainder=4'b0000; with DIV_OVERFLOW_FLAG_EN, overflow=1.
- dividend=4'b0101 (+5), divisor=4'b0000 -> done at edge 5; quotient=4'b1111, remainder=4'b0101, div_by_zero=1.
- dividend=4'b0110, divisor=4'b0011 -> quotient=4'b0010, remainder=0. Then start a new division and drop rst_n during CALC -> all outputs immediately 0, no done pulse; a subsequent operation completes normally.
- Exhaustive sweep of all 256 operand pairs -> results match a reference model following the sign rules; every operation completes in exactly WIDTH+1 cycles.
